// File: rtl/key_event_ctrl.sv
// key_event_ctrl: classifies debounced key press/release pulses into short press,
// long press (with auto-repeat while held) and double click gestures.
// One shared timer is sequenced by a five-state FSM. All outputs are registered.
module key_event_ctrl #(
  parameter int CNT_W      = 26,
  parameter int LONG_CNT   = 50_000_000,
  parameter int DCLICK_CNT = 15_000_000,
  parameter int REPEAT_CNT = 10_000_000
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic Key_P_Flag,
  input  logic Key_R_Flag,
  output logic Short_Flag,
  output logic Long_Flag,
  output logic Repeat_Flag,
  output logic Double_Flag,
  output logic Key_Held
);

  // Terminal timer values; the timer counts 0..N-1 so an N-cycle interval ends at N-1.
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CNT - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRESS1 = 3'd1,
    S_LONG   = 3'd2,
    S_WAIT2  = 3'd3,
    S_PRESS2 = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             p_evt;
  logic             r_evt;

  // A simultaneous press and release is treated as a release only.
  assign p_evt = Key_P_Flag & ~Key_R_Flag;
  assign r_evt = Key_R_Flag;

  // Gesture FSM with shared timer and registered event/level outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      Short_Flag  <= 1'b0;
      Long_Flag   <= 1'b0;
      Repeat_Flag <= 1'b0;
      Double_Flag <= 1'b0;
      Key_Held    <= 1'b0;
    end else begin
      Short_Flag  <= 1'b0;
      Long_Flag   <= 1'b0;
      Repeat_Flag <= 1'b0;
      Double_Flag <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (p_evt) begin
            state    <= S_PRESS1;
            Key_Held <= 1'b1;
          end
        end
        S_PRESS1: begin
          // A release wins over the long-press timeout landing in the same cycle.
          if (r_evt) begin
            state    <= S_WAIT2;
            cnt      <= '0;
            Key_Held <= 1'b0;
          end else if (cnt == LONG_LAST) begin
            state     <= S_LONG;
            cnt       <= '0;
            Long_Flag <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_LONG: begin
          if (r_evt) begin
            state    <= S_IDLE;
            cnt      <= '0;
            Key_Held <= 1'b0;
          end else if (cnt == REPEAT_LAST) begin
            cnt         <= '0;
            Repeat_Flag <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT2: begin
          // Stray releases here are ignored and do not disturb the click window.
          if (p_evt) begin
            state    <= S_PRESS2;
            cnt      <= '0;
            Key_Held <= 1'b1;
          end else if (cnt == DCLICK_LAST) begin
            state      <= S_IDLE;
            cnt        <= '0;
            Short_Flag <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PRESS2: begin
          // Untimed: holding the second press never turns into a long press.
          cnt <= '0;
          if (r_evt) begin
            state       <= S_IDLE;
            Key_Held    <= 1'b0;
            Double_Flag <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          cnt      <= '0;
          Key_Held <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Testbench for key_event_ctrl: directed gesture scenarios with literal expectations
// plus randomized press/release traffic against a timestamp-based gesture model.
module tb_key_event_ctrl;

  localparam int CNT_W      = 8;
  localparam int LONG_CNT   = 20;
  localparam int DCLICK_CNT = 8;
  localparam int REPEAT_CNT = 5;

  logic Clk;
  logic Reset_n;
  logic Key_P_Flag;
  logic Key_R_Flag;
  logic Short_Flag;
  logic Long_Flag;
  logic Repeat_Flag;
  logic Double_Flag;
  logic Key_Held;

  int nvec;
  int nerr;

  key_event_ctrl #(
    .CNT_W      (CNT_W),
    .LONG_CNT   (LONG_CNT),
    .DCLICK_CNT (DCLICK_CNT),
    .REPEAT_CNT (REPEAT_CNT)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Key_P_Flag  (Key_P_Flag),
    .Key_R_Flag  (Key_R_Flag),
    .Short_Flag  (Short_Flag),
    .Long_Flag   (Long_Flag),
    .Repeat_Flag (Repeat_Flag),
    .Double_Flag (Double_Flag),
    .Key_Held    (Key_Held)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Gesture model: tracks how many presses the current gesture has seen, whether the
  // key is down, and the edge numbers of the last press/release. Flags follow from
  // elapsed edge counts rather than from a running timer.
  typedef struct {
    int n;
    int presses;
    bit held;
    bit islong;
    int t_press;
    int t_rel;
    bit sh;
    bit lg;
    bit rp;
    bit db;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.n = 0; r.presses = 0; r.held = 0; r.islong = 0;
    r.t_press = 0; r.t_rel = 0;
    r.sh = 0; r.lg = 0; r.rp = 0; r.db = 0;
    return r;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t s, input logic p_in, input logic r_in);
    mdl_t x;
    bit   done;
    int   e;
    x = s;
    done = 0;
    x.n = s.n + 1;
    x.sh = 0; x.lg = 0; x.rp = 0; x.db = 0;
    if (r_in && x.held) begin
      done = 1;
      x.held = 0;
      if (x.presses == 2) begin
        x.db = 1;
        x.presses = 0;
      end else if (x.islong) begin
        x.presses = 0;
      end else begin
        x.t_rel = x.n;
      end
    end else if (p_in && !r_in && !x.held) begin
      done = 1;
      x.held = 1;
      if (x.presses == 0) begin
        x.presses = 1;
        x.t_press = x.n;
        x.islong = 0;
      end else begin
        x.presses = 2;
      end
    end
    if (!done) begin
      if (x.held && x.presses == 1) begin
        e = x.n - x.t_press;
        if (e == LONG_CNT) begin
          x.lg = 1;
          x.islong = 1;
        end else if (x.islong && e > LONG_CNT && ((e - LONG_CNT) % REPEAT_CNT) == 0) begin
          x.rp = 1;
        end
      end else if (!x.held && x.presses == 1) begin
        e = x.n - x.t_rel;
        if (e == DCLICK_CNT) begin
          x.sh = 1;
          x.presses = 0;
        end
      end
    end
    return x;
  endfunction

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) m <= mdl_reset();
    else          m <= mdl_step(m, Key_P_Flag, Key_R_Flag);
  end

  task automatic check(input string name, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, away from the active edge, compare DUT outputs against the model.
  always @(negedge Clk) begin
    check("model_short",  Short_Flag,  m.sh);
    check("model_long",   Long_Flag,   m.lg);
    check("model_repeat", Repeat_Flag, m.rp);
    check("model_double", Double_Flag, m.db);
    check("model_held",   Key_Held,    m.held);
    check("one_hot", 1'b1,
          ((32'(Short_Flag) + 32'(Long_Flag) + 32'(Repeat_Flag) + 32'(Double_Flag)) <= 1) ? 1'b1 : 1'b0);
  end

  // Drive one input pattern for exactly one sampling edge; returns 2 time units after it.
  task automatic pulse(input logic p, input logic r);
    Key_P_Flag = p;
    Key_R_Flag = r;
    @(posedge Clk);
    #2;
    Key_P_Flag = 1'b0;
    Key_R_Flag = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge Clk);
      #2;
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    Key_P_Flag = 1'b0;
    Key_R_Flag = 1'b0;
    Reset_n = 1'b0;
    #1;
    check("reset_held",  Key_Held, 1'b0);
    check("reset_short", Short_Flag, 1'b0);
    check("reset_long",  Long_Flag, 1'b0);
    idle(3);
    Reset_n = 1'b1;
    idle(2);

    // Short press: P at t, R at t+5, Short_Flag after t+13.
    pulse(1'b1, 1'b0);
    idle(4);
    check("short_held_hi", Key_Held, 1'b1);
    pulse(1'b0, 1'b1);
    check("short_held_lo", Key_Held, 1'b0);
    idle(7);
    check("short_early", Short_Flag, 1'b0);
    idle(1);
    check("short_pulse", Short_Flag, 1'b1);
    idle(1);
    check("short_single", Short_Flag, 1'b0);
    idle(3);

    // Double click: R t+3, P t+7, R t+10.
    pulse(1'b1, 1'b0);
    idle(2);
    pulse(1'b0, 1'b1);
    idle(3);
    pulse(1'b1, 1'b0);
    check("dbl_held_2nd", Key_Held, 1'b1);
    idle(2);
    pulse(1'b0, 1'b1);
    check("dbl_pulse", Double_Flag, 1'b1);
    check("dbl_held_lo", Key_Held, 1'b0);
    idle(1);
    check("dbl_single", Double_Flag, 1'b0);
    idle(12);

    // Long hold with repeats, release at t+32.
    pulse(1'b1, 1'b0);
    idle(19);
    check("long_early", Long_Flag, 1'b0);
    idle(1);
    check("long_pulse", Long_Flag, 1'b1);
    idle(5);
    check("repeat_1", Repeat_Flag, 1'b1);
    idle(1);
    check("repeat_1_end", Repeat_Flag, 1'b0);
    idle(4);
    check("repeat_2", Repeat_Flag, 1'b1);
    idle(1);
    pulse(1'b0, 1'b1);
    check("long_rel_held", Key_Held, 1'b0);
    idle(12);
    check("long_no_short", Short_Flag, 1'b0);

    // Long boundary race: R at t+20 beats the timeout.
    pulse(1'b1, 1'b0);
    idle(19);
    pulse(1'b0, 1'b1);
    check("race_no_long", Long_Flag, 1'b0);
    idle(7);
    check("race_short_early", Short_Flag, 1'b0);
    idle(1);
    check("race_short", Short_Flag, 1'b1);
    idle(3);

    // Reset mid-gesture while in LONG.
    pulse(1'b1, 1'b0);
    idle(22);
    check("rst_pre_held", Key_Held, 1'b1);
    #1;
    Reset_n = 1'b0;
    #1;
    check("rst_async_held", Key_Held, 1'b0);
    check("rst_async_rep",  Repeat_Flag, 1'b0);
    idle(3);
    Reset_n = 1'b1;
    idle(2);
    pulse(1'b0, 1'b1);
    check("rst_stray_r", Key_Held, 1'b0);
    idle(10);
    check("rst_stray_short", Short_Flag, 1'b0);
    pulse(1'b1, 1'b0);
    check("rst_new_press", Key_Held, 1'b1);
    idle(20);
    check("rst_new_long", Long_Flag, 1'b1);
    pulse(1'b0, 1'b1);
    idle(3);

    // Simultaneous P+R in IDLE and stray P in PRESS1.
    pulse(1'b1, 1'b1);
    check("simul_idle", Key_Held, 1'b0);
    idle(2);
    pulse(1'b1, 1'b0);
    idle(5);
    pulse(1'b1, 1'b0);
    idle(13);
    check("stray_p_early", Long_Flag, 1'b0);
    idle(1);
    check("stray_p_long", Long_Flag, 1'b1);
    pulse(1'b0, 1'b1);
    idle(3);

    // Randomized traffic, with occasional asynchronous resets.
    for (int i = 0; i < 6000; i++) begin
      Key_P_Flag = ($urandom_range(0, 17) == 0);
      Key_R_Flag = ($urandom_range(0, 27) == 0);
      if ($urandom_range(0, 1499) == 0) begin
        #1;
        Reset_n = 1'b0;
        #1;
        check("rand_rst_held", Key_Held, 1'b0);
        Reset_n = 1'b1;
      end
      @(posedge Clk);
      #2;
    end
    Key_P_Flag = 1'b0;
    Key_R_Flag = 1'b0;
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
